npc_unit: RTL and testbench
===========================

NPC_UNIT -- requirements
Module: npc_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_3000, meaning the fetch address loaded on reset.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port stall  input  1  hazard stall; holds the F and D PC state.
REQ-005 SHALL have port ctrl_op  input  3  decoded D-stage transfer: 0 none, 1 branch, 2 j/jal, 3 jr/jalr, 4 branch-likely; 5-7 treated as 0.
REQ-006 SHALL have port branch  input  1  D-stage condition result from the branch comparator.
REQ-007 SHALL have port imm16_d  input  16  D-stage branch offset field.
REQ-008 SHALL have port index26_d  input  26  D-stage jump index field.
REQ-009 SHALL have port rs_val_d  input  32  forwarded rs value, the jr/jalr target.
REQ-010 SHALL have port pc_f  output  32  current fetch address (register).
REQ-011 SHALL have port pc_d  output  32  PC of the instruction in D (register).
REQ-012 SHALL have port link_d  output  32  pc_d + 8, the jal/jalr link value.
REQ-013 SHALL have port bd_d  output  1  D instruction is a delay-slot instruction (register).
REQ-014 SHALL have port flush_fd  output  1  annul the IF/ID register this cycle.
REQ-015 SHALL have port align_err  output  1  one-cycle registered pulse: the last redirect had a misaligned target.

Function
REQ-016 With stall=0 at an edge, pc_d SHALL load pc_f and bd_d SHALL load (ctrl_op in {1,2,3,4}).
REQ-017 Next pc_f SHALL be: op 0 or not-taken branch -> pc_f+4; taken branch -> pc_d+4+(sign-extended imm16_d<<2); op 2 -> {pc_d[31:28], index26_d, 2'b00}; op 3 -> {rs_val_d[31:2], 2'b00}.
REQ-018 All address arithmetic SHALL be 32-bit modulo 2^32; pc_f 32'hFFFF_FFFC SHALL advance to 32'h0000_0000 without a flag.
REQ-019 A branch SHALL be taken when ctrl_op is 1 or 4 and branch=1.
REQ-020 Op 3 with rs_val_d[1:0] != 0 SHALL still redirect to the aligned address and set align_err for exactly the next cycle.
REQ-021 With stall=1, pc_f, pc_d and bd_d SHALL hold; flush_fd SHALL be 0; align_err SHALL clear.
REQ-022 link_d SHALL be combinational and valid every cycle, including during stall.
REQ-023 Latency SHALL be one cycle: the redirect target appears on pc_f the edge after the transfer is in D with stall=0, so the instruction already in F (pc_d+4) is the delay slot.
REQ-024 When a transfer sits in D while the delay slot is already flushed (bd_d=0 after flush), the transfer SHALL still be resolved normally.

Reset
REQ-025 With reset=1 at an edge: pc_f=RESET_PC, pc_d=32'h0, bd_d=0, align_err=0; flush_fd SHALL be 0 while reset=1.
REQ-026 reset SHALL dominate stall and any ctrl_op, including mid-redirect; the redirect is discarded.

Configuration
REQ-027 Macro NPC_BRANCH_LIKELY_EN SHALL gate branch-likely support.
REQ-028 With NPC_BRANCH_LIKELY_EN defined, op 4 with branch=0 and stall=0 SHALL assert flush_fd combinationally that cycle; at the next edge pc_f=pc_f+4 and bd_d=0.
REQ-029 Without NPC_BRANCH_LIKELY_EN, op 4 SHALL behave exactly as op 1 and flush_fd SHALL be constant 0.

Verification
REQ-030 Reset then 3 idle cycles, op 0 -> pc_f 3000, 3004, 3008, 300C; pc_d trails by one cycle; bd_d=0.
REQ-031 pc_d=3004, op 1, branch=1, imm16=16'hFFFE -> next pc_f=3000; bd_d=1 the following cycle; link_d=300C.
REQ-032 op 2 at pc_d=0040_1000, index26=26'h0000400 -> pc_f=0000_1000; same op held with stall=1 for 2 cycles -> pc_f, pc_d unchanged until stall drops.
REQ-033 op 3, rs_val_d=0000_3016 -> pc_f=0000_3014, align_err=1 for one cycle; then rs_val_d=3010 -> align_err=0.
REQ-034 With NPC_BRANCH_LIKELY_EN: op 4, branch=0 -> flush_fd=1 one cycle, bd_d=0 next; without the macro -> flush_fd=0, bd_d=1.
REQ-035 reset asserted together with a taken branch and stall=1 -> pc_f=RESET_PC, pc_d=0, flush_fd=0; pc_f at FFFF_FFFC with op 0 -> 0000_0000.

Source files
------------

// File: rtl/npc_unit.sv
// Next-PC unit: fetch/decode PC registers, branch/jump redirect with one delay slot.
// Optional branch-likely delay-slot annulment is enabled by defining NPC_BRANCH_LIKELY_EN.
module npc_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [2:0]  ctrl_op,
    input  logic        branch,
    input  logic [15:0] imm16_d,
    input  logic [25:0] index26_d,
    input  logic [31:0] rs_val_d,
    output logic [31:0] pc_f,
    output logic [31:0] pc_d,
    output logic [31:0] link_d,
    output logic        bd_d,
    output logic        flush_fd,
    output logic        align_err
);

    localparam logic [2:0] OP_NONE   = 3'd0;
    localparam logic [2:0] OP_BRANCH = 3'd1;
    localparam logic [2:0] OP_JUMP   = 3'd2;
    localparam logic [2:0] OP_JR     = 3'd3;
    localparam logic [2:0] OP_LIKELY = 3'd4;

    logic [31:0] seq_pc;
    logic [31:0] branch_target;
    logic [31:0] next_pc;
    logic        is_xfer;
    logic        taken;
    logic        likely_kill;
    logic        misaligned;

    assign seq_pc        = pc_f + 32'd4;
    assign branch_target = pc_d + 32'd4 + {{14{imm16_d[15]}}, imm16_d, 2'b00};
    assign link_d        = pc_d + 32'd8;

    // Codes 5-7 fall outside this set and so decode as "no transfer".
    assign is_xfer    = (ctrl_op == OP_BRANCH) || (ctrl_op == OP_JUMP) ||
                        (ctrl_op == OP_JR)     || (ctrl_op == OP_LIKELY);
    assign taken      = ((ctrl_op == OP_BRANCH) || (ctrl_op == OP_LIKELY)) && branch;
    assign misaligned = (ctrl_op == OP_JR) && (rs_val_d[1:0] != 2'b00);

`ifdef NPC_BRANCH_LIKELY_EN
    // A not-taken branch-likely annuls the delay slot already fetched into F.
    assign likely_kill = (ctrl_op == OP_LIKELY) && !branch;
`else
    assign likely_kill = 1'b0;
`endif

    assign flush_fd = likely_kill && !stall && !reset;

    always_comb begin
        next_pc = seq_pc;
        case (ctrl_op)
            OP_JUMP: next_pc = {pc_d[31:28], index26_d, 2'b00};
            OP_JR:   next_pc = {rs_val_d[31:2], 2'b00};
            default: if (taken) next_pc = branch_target;
        endcase
    end

    // NOTE: all state uses non-blocking assignments so every register samples
    // pre-edge values; blocking here would let pc_d see the freshly updated pc_f.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_f      <= RESET_PC;
            pc_d      <= 32'h0;
            bd_d      <= 1'b0;
            align_err <= 1'b0;
        end else if (stall) begin
            align_err <= 1'b0;
        end else begin
            pc_f      <= next_pc;
            pc_d      <= pc_f;
            bd_d      <= is_xfer && !likely_kill;
            align_err <= misaligned;
        end
    end

endmodule

// File: tb/tb_npc_unit.sv
// Scoreboard bench for npc_unit: stimulus queues hand-computed observations,
// a negedge monitor pops and compares them. Works with or without NPC_BRANCH_LIKELY_EN.
module tb_npc_unit;

    logic        clk = 1'b0;
    logic        reset, stall, branch;
    logic [2:0]  ctrl_op;
    logic [15:0] imm16_d;
    logic [25:0] index26_d;
    logic [31:0] rs_val_d;
    logic [31:0] pc_f, pc_d, link_d;
    logic        bd_d, flush_fd, align_err;

`ifdef NPC_BRANCH_LIKELY_EN
    localparam bit BL = 1'b1;
`else
    localparam bit BL = 1'b0;
`endif

    typedef struct {
        string       name;
        logic [31:0] pcf;
        logic [31:0] pcd;
        logic        bd;
        logic        ae;
        logic [31:0] link;
        logic        fl;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    npc_unit #(.RESET_PC(32'h0000_3000)) dut (
        .clk       (clk),
        .reset     (reset),
        .stall     (stall),
        .ctrl_op   (ctrl_op),
        .branch    (branch),
        .imm16_d   (imm16_d),
        .index26_d (index26_d),
        .rs_val_d  (rs_val_d),
        .pc_f      (pc_f),
        .pc_d      (pc_d),
        .link_d    (link_d),
        .bd_d      (bd_d),
        .flush_fd  (flush_fd),
        .align_err (align_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Monitor: inputs settle 1ns after posedge, so mid-cycle shows this cycle's
    // combinational outputs and the registers from the previous edge.
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                check({e.name, ".pc_f"},      pc_f,      e.pcf);
                check({e.name, ".pc_d"},      pc_d,      e.pcd);
                check({e.name, ".bd_d"},      {31'b0, bd_d},      {31'b0, e.bd});
                check({e.name, ".align_err"}, {31'b0, align_err}, {31'b0, e.ae});
                check({e.name, ".link_d"},    link_d,    e.link);
                check({e.name, ".flush_fd"},  {31'b0, flush_fd},  {31'b0, e.fl});
            end
        end
    end

    task automatic drive(input logic rst, input logic stl, input logic [2:0] op, input logic br,
                         input logic [15:0] imm, input logic [25:0] idx, input logic [31:0] rs);
        @(posedge clk);
        #1;
        reset     = rst;
        stall     = stl;
        ctrl_op   = op;
        branch    = br;
        imm16_d   = imm;
        index26_d = idx;
        rs_val_d  = rs;
    endtask

    task automatic expect_obs(input string name, input logic [31:0] pcf, input logic [31:0] pcd,
                              input logic bd, input logic ae, input logic [31:0] link, input logic fl);
        exp_t e;
        e.name = name; e.pcf = pcf; e.pcd = pcd; e.bd = bd;
        e.ae = ae; e.link = link; e.fl = fl;
        exp_q.push_back(e);
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; ctrl_op = 3'd0; branch = 1'b0;
        imm16_d = '0; index26_d = '0; rs_val_d = '0;

        drive(1, 0, 0, 0, 16'h0, 26'h0, 32'h0);
        drive(1, 0, 0, 0, 16'h0, 26'h0, 32'h0);
        expect_obs("reset",     32'h3000, 32'h0,    0, 0, 32'h8,    0);
        // Sequential fetch.
        drive(0, 0, 0, 0, 16'h0, 26'h0, 32'h0);
        expect_obs("idle0",     32'h3000, 32'h0,    0, 0, 32'h8,    0);
        drive(0, 0, 0, 0, 16'h0, 26'h0, 32'h0);
        expect_obs("idle1",     32'h3004, 32'h3000, 0, 0, 32'h3008, 0);
        drive(0, 0, 0, 0, 16'h0, 26'h0, 32'h0);
        expect_obs("idle2",     32'h3008, 32'h3004, 0, 0, 32'h300C, 0);
        drive(0, 0, 0, 0, 16'h0, 26'h0, 32'h0);
        expect_obs("idle3",     32'h300C, 32'h3008, 0, 0, 32'h3010, 0);
        // jr back to 3004 so pc_d reaches 3004 for the backward branch.
        drive(0, 0, 3, 0, 16'h0, 26'h0, 32'h3004);
        expect_obs("jr3004",    32'h3010, 32'h300C, 0, 0, 32'h3014, 0);
        drive(0, 0, 0, 0, 16'h0, 26'h0, 32'h0);
        expect_obs("jr_ds",     32'h3004, 32'h3010, 1, 0, 32'h3018, 0);
        drive(0, 0, 1, 1, 16'hFFFE, 26'h0, 32'h0);
        expect_obs("br_back",   32'h3008, 32'h3004, 0, 0, 32'h300C, 0);
        drive(0, 0, 1, 0, 16'h0010, 26'h0, 32'h0);
        expect_obs("br_nt",     32'h3000, 32'h3008, 1, 0, 32'h3010, 0);
        drive(0, 0, 0, 0, 16'h0, 26'h0, 32'h0);
        expect_obs("br_nt_ds",  32'h3004, 32'h3000, 1, 0, 32'h3008, 0);
        // Reach pc_d = 0040_1000 and test j with stall.
        drive(0, 0, 3, 0, 16'h0, 26'h0, 32'h0040_1000);
        expect_obs("jr_far",    32'h3008, 32'h3004, 0, 0, 32'h300C, 0);
        drive(0, 0, 0, 0, 16'h0, 26'h0, 32'h0);
        expect_obs("far_ds",    32'h0040_1000, 32'h3008, 1, 0, 32'h3010, 0);
        drive(0, 1, 2, 0, 16'h0, 26'h000_0400, 32'h0);
        expect_obs("j_stall0",  32'h0040_1004, 32'h0040_1000, 0, 0, 32'h0040_1008, 0);
        drive(0, 1, 2, 0, 16'h0, 26'h000_0400, 32'h0);
        expect_obs("j_stall1",  32'h0040_1004, 32'h0040_1000, 0, 0, 32'h0040_1008, 0);
        drive(0, 0, 2, 0, 16'h0, 26'h000_0400, 32'h0);
        expect_obs("j_go",      32'h0040_1004, 32'h0040_1000, 0, 0, 32'h0040_1008, 0);
        // Misaligned jr.
        drive(0, 0, 3, 0, 16'h0, 26'h0, 32'h0000_3016);
        expect_obs("j_done",    32'h0000_1000, 32'h0040_1004, 1, 0, 32'h0040_100C, 0);
        drive(0, 0, 3, 0, 16'h0, 26'h0, 32'h0000_3010);
        expect_obs("jr_mis",    32'h3014, 32'h1000, 1, 1, 32'h1008, 0);
        drive(0, 0, 3, 0, 16'h0, 26'h0, 32'h0000_3017);
        expect_obs("jr_ok",     32'h3010, 32'h3014, 1, 0, 32'h301C, 0);
        drive(0, 1, 0, 0, 16'h0, 26'h0, 32'h0);
        expect_obs("jr_mis2",   32'h3014, 32'h3010, 1, 1, 32'h3018, 0);
        // Branch-likely not taken, then with stall, then taken after a flushed slot.
        drive(0, 0, 4, 0, 16'h0, 26'h0, 32'h0);
        expect_obs("bl_nt",     32'h3014, 32'h3010, 1, 0, 32'h3018, BL);
        drive(0, 1, 4, 0, 16'h0, 26'h0, 32'h0);
        expect_obs("bl_stall",  32'h3018, 32'h3014, !BL, 0, 32'h301C, 0);
        drive(0, 0, 4, 1, 16'h0004, 26'h0, 32'h0);
        expect_obs("bl_taken",  32'h3018, 32'h3014, !BL, 0, 32'h301C, 0);
        drive(0, 0, 5, 1, 16'h0004, 26'h0, 32'h0);
        expect_obs("op5",       32'h3028, 32'h3018, 1, 0, 32'h3020, 0);
        // Reset dominates a stalled taken branch.
        drive(1, 1, 1, 1, 16'hFFFE, 26'h0, 32'h0);
        expect_obs("op5_after", 32'h302C, 32'h3028, 0, 0, 32'h3030, 0);
        // Wrap at the top of the address space.
        drive(0, 0, 3, 0, 16'h0, 26'h0, 32'hFFFF_FFFC);
        expect_obs("rst_dom",   32'h3000, 32'h0, 0, 0, 32'h8, 0);
        drive(0, 0, 0, 0, 16'h0, 26'h0, 32'h0);
        expect_obs("top",       32'hFFFF_FFFC, 32'h3000, 1, 0, 32'h3008, 0);
        drive(0, 0, 0, 0, 16'h0, 26'h0, 32'h0);
        expect_obs("wrap",      32'h0, 32'hFFFF_FFFC, 0, 0, 32'h4, 0);
        // flush_fd held low under reset even for a not-taken branch-likely.
        drive(1, 0, 4, 0, 16'h0, 26'h0, 32'h0);
        expect_obs("rst_bl",    32'h4, 32'h0, 0, 0, 32'h8, 0);
        drive(0, 0, 0, 0, 16'h0, 26'h0, 32'h0);
        expect_obs("post_rst",  32'h3000, 32'h0, 0, 0, 32'h8, 0);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        @(posedge clk);
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
